// File: rtl/eq_seq_ctrl_pkg.sv
// Shared definitions for the equaliser sequencing controller.
// Holds the address-width helper, the widths for the default queue depths
// and the pass-sequencing FSM state encoding.
package eq_seq_ctrl_pkg;

    // Address width for a queue of the given depth (never below 1 bit).
    function automatic int unsigned addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int unsigned LF_DEPTH_DEF = 1021;
    localparam int unsigned HF_DEPTH_DEF = 1531;
    localparam int unsigned LF_AW        = addr_w(LF_DEPTH_DEF);
    localparam int unsigned HF_AW        = addr_w(HF_DEPTH_DEF);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CLR  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

endpackage

// File: rtl/mod_addr_ctr.sv
// Wrapping address counter with synchronous load and increment.
// Ports:
//   clk, rst   clock and synchronous active-high reset (clears to 0)
//   load       load load_val (has priority over inc)
//   load_val   value to load
//   inc        advance by one, wrapping from DEPTH-1 to 0
//   cnt        current count
module mod_addr_ctr #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] cnt
);

    logic [AW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (inc) begin
            cnt_q <= (cnt_q == AW'(DEPTH - 1)) ? '0 : cnt_q + 1'b1;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/eq_seq_ctrl.sv
// Equaliser queue/filter-pass sequencer.
// Writes every sample pair into the HF queues and every other pair into the
// LF queues, then, once both queues are full, runs one filter pass of
// HF_DEPTH taps per new sample (LF taps only on passes that wrote LF).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   valid_rise               new sample pair strobe
//   lf_wr_en/addr            LF queue write
//   hf_wr_en/addr            HF queue write
//   lf_rd_addr, hf_rd_addr   queue read addresses during a pass
//   coef_addr                shared coefficient tap index
//   acc_clr                  clear band accumulators
//   lf_acc_en, hf_acc_en     accumulate enables
//   lf_out_latch, hf_out_latch  latch band results
//   sequencing               pass in progress
//   overrun                  sample request dropped
module eq_seq_ctrl #(
    parameter int unsigned LF_DEPTH = 1021,
    parameter int unsigned HF_DEPTH = 1531,
    localparam int unsigned LF_AW = eq_seq_ctrl_pkg::addr_w(LF_DEPTH),
    localparam int unsigned HF_AW = eq_seq_ctrl_pkg::addr_w(HF_DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_rise,
    output logic             lf_wr_en,
    output logic [LF_AW-1:0] lf_wr_addr,
    output logic             hf_wr_en,
    output logic [HF_AW-1:0] hf_wr_addr,
    output logic [LF_AW-1:0] lf_rd_addr,
    output logic [HF_AW-1:0] hf_rd_addr,
    output logic [HF_AW-1:0] coef_addr,
    output logic             acc_clr,
    output logic             lf_acc_en,
    output logic             hf_acc_en,
    output logic             lf_out_latch,
    output logic             hf_out_latch,
    output logic             sequencing,
    output logic             overrun
);
    import eq_seq_ctrl_pkg::*;

    localparam int unsigned FW = addr_w(HF_DEPTH + 1);

    state_e        state_q, state_d;
    logic          pending_q, pending_d;
    logic          pend_lf_q, pend_lf_d;   // a pending-period rise wrote LF
    logic          pass_lf_q, pass_lf_d;   // current pass includes LF taps
    logic          overrun_d;
    logic          lf_phase_q;             // 0: next rise writes LF
    logic [FW-1:0] lf_fill_q, hf_fill_q, lf_fill_nxt, hf_fill_nxt;

    logic             lf_wr, hf_wr, full, start, run_d, lf_act;
    logic [LF_AW-1:0] lf_ptr, lf_ptr_inc, lf_base, lf_rd_cnt;
    logic [HF_AW-1:0] hf_ptr, hf_ptr_inc, hf_base, hf_rd_cnt, k_cnt;

    assign hf_wr = valid_rise;
    assign lf_wr = valid_rise && !lf_phase_q;

    // Read bases point at the oldest sample: write pointers after this cycle's write.
    assign lf_ptr_inc = (lf_ptr == LF_AW'(LF_DEPTH - 1)) ? '0 : lf_ptr + 1'b1;
    assign hf_ptr_inc = (hf_ptr == HF_AW'(HF_DEPTH - 1)) ? '0 : hf_ptr + 1'b1;
    assign lf_base    = lf_wr ? lf_ptr_inc : lf_ptr;
    assign hf_base    = hf_wr ? hf_ptr_inc : hf_ptr;

    assign lf_fill_nxt = (lf_wr && lf_fill_q != FW'(LF_DEPTH)) ? lf_fill_q + 1'b1 : lf_fill_q;
    assign hf_fill_nxt = (hf_wr && hf_fill_q != FW'(HF_DEPTH)) ? hf_fill_q + 1'b1 : hf_fill_q;
    assign full        = (lf_fill_nxt == FW'(LF_DEPTH)) && (hf_fill_nxt == FW'(HF_DEPTH));

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        pend_lf_d = pend_lf_q;
        pass_lf_d = pass_lf_q;
        overrun_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (valid_rise && full) begin
                    state_d   = ST_CLR;
                    pass_lf_d = lf_wr;
                end
            end
            ST_CLR: state_d = ST_RUN;
            // coef_addr holds the current tap index while running
            ST_RUN: if (coef_addr == HF_AW'(HF_DEPTH - 1)) state_d = ST_DONE;
            ST_DONE: begin
                if (pending_q || valid_rise) begin
                    state_d   = ST_CLR;
                    pass_lf_d = pend_lf_q | lf_wr;
                    overrun_d = pending_q && valid_rise;
                end else begin
                    state_d = ST_IDLE;
                end
                pending_d = 1'b0;
                pend_lf_d = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
        if ((state_q == ST_CLR || state_q == ST_RUN) && valid_rise) begin
            if (pending_q) begin
                overrun_d = 1'b1;
                pend_lf_d = pend_lf_q | lf_wr;
            end else begin
                pending_d = 1'b1;
                pend_lf_d = lf_wr;
            end
        end
    end

    assign start  = (state_d == ST_CLR);
    assign run_d  = (state_d == ST_RUN);
    assign lf_act = run_d && pass_lf_q && (32'(k_cnt) < LF_DEPTH);

    mod_addr_ctr #(.DEPTH(LF_DEPTH), .AW(LF_AW)) u_lf_wr_ptr (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0), .inc(lf_wr), .cnt(lf_ptr)
    );
    mod_addr_ctr #(.DEPTH(HF_DEPTH), .AW(HF_AW)) u_hf_wr_ptr (
        .clk(clk), .rst(rst), .load(1'b0), .load_val('0), .inc(hf_wr), .cnt(hf_ptr)
    );
    // Tap index and read addresses hold the value to present next cycle.
    mod_addr_ctr #(.DEPTH(HF_DEPTH), .AW(HF_AW)) u_k_ctr (
        .clk(clk), .rst(rst), .load(start), .load_val('0), .inc(run_d), .cnt(k_cnt)
    );
    mod_addr_ctr #(.DEPTH(HF_DEPTH), .AW(HF_AW)) u_hf_rd_ctr (
        .clk(clk), .rst(rst), .load(start), .load_val(hf_base), .inc(run_d), .cnt(hf_rd_cnt)
    );
    mod_addr_ctr #(.DEPTH(LF_DEPTH), .AW(LF_AW)) u_lf_rd_ctr (
        .clk(clk), .rst(rst), .load(start), .load_val(lf_base), .inc(lf_act), .cnt(lf_rd_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            pend_lf_q    <= 1'b0;
            pass_lf_q    <= 1'b0;
            lf_phase_q   <= 1'b0;
            lf_fill_q    <= '0;
            hf_fill_q    <= '0;
            lf_wr_en     <= 1'b0;
            lf_wr_addr   <= '0;
            hf_wr_en     <= 1'b0;
            hf_wr_addr   <= '0;
            lf_rd_addr   <= '0;
            hf_rd_addr   <= '0;
            coef_addr    <= '0;
            acc_clr      <= 1'b0;
            lf_acc_en    <= 1'b0;
            hf_acc_en    <= 1'b0;
            lf_out_latch <= 1'b0;
            hf_out_latch <= 1'b0;
            sequencing   <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            pend_lf_q    <= pend_lf_d;
            pass_lf_q    <= pass_lf_d;
            lf_phase_q   <= lf_phase_q ^ valid_rise;
            lf_fill_q    <= lf_fill_nxt;
            hf_fill_q    <= hf_fill_nxt;
            lf_wr_en     <= lf_wr;
            lf_wr_addr   <= lf_wr ? lf_ptr : '0;
            hf_wr_en     <= hf_wr;
            hf_wr_addr   <= hf_wr ? hf_ptr : '0;
            acc_clr      <= start;
            coef_addr    <= run_d ? k_cnt : '0;
            hf_rd_addr   <= run_d ? hf_rd_cnt : '0;
            hf_acc_en    <= run_d;
            lf_rd_addr   <= lf_act ? lf_rd_cnt : '0;
            lf_acc_en    <= lf_act;
            hf_out_latch <= (state_d == ST_DONE);
            lf_out_latch <= (state_d == ST_DONE) && pass_lf_q;
            sequencing   <= (state_d != ST_IDLE);
            overrun      <= overrun_d;
        end
    end

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// Self-checking bench for eq_seq_ctrl with LF_DEPTH=5, HF_DEPTH=7.
module tb_eq_seq_ctrl;
    localparam int LFD = 5;
    localparam int HFD = 7;

    logic       clk = 1'b0;
    logic       rst, valid_rise;
    logic       lf_wr_en, hf_wr_en, acc_clr, lf_acc_en, hf_acc_en;
    logic       lf_out_latch, hf_out_latch, sequencing, overrun;
    logic [2:0] lf_wr_addr, hf_wr_addr, lf_rd_addr, hf_rd_addr, coef_addr;

    always #5 clk = ~clk;

    eq_seq_ctrl #(.LF_DEPTH(LFD), .HF_DEPTH(HFD)) dut (
        .clk(clk), .rst(rst), .valid_rise(valid_rise),
        .lf_wr_en(lf_wr_en), .lf_wr_addr(lf_wr_addr),
        .hf_wr_en(hf_wr_en), .hf_wr_addr(hf_wr_addr),
        .lf_rd_addr(lf_rd_addr), .hf_rd_addr(hf_rd_addr), .coef_addr(coef_addr),
        .acc_clr(acc_clr), .lf_acc_en(lf_acc_en), .hf_acc_en(hf_acc_en),
        .lf_out_latch(lf_out_latch), .hf_out_latch(hf_out_latch),
        .sequencing(sequencing), .overrun(overrun)
    );

    typedef struct packed {
        logic       acc_clr, lf_acc_en, hf_acc_en, lf_out_latch, hf_out_latch;
        logic       sequencing, overrun;
        logic [2:0] lf_rd, hf_rd, coef;
    } obs_t;
    typedef struct { logic vr; obs_t exp; } row_t;
    typedef struct packed { logic lf_en; logic [2:0] lf_addr; logic [2:0] hf_addr; } wr_t;

    wr_t  wr_q[$];
    row_t rows[9];
    int   checks = 0;
    int   failures = 0;
    int   n_rise = 0;
    logic seq_seen;

    function automatic obs_t observe();
        obs_t o;
        o.acc_clr = acc_clr;           o.lf_acc_en = lf_acc_en;
        o.hf_acc_en = hf_acc_en;       o.lf_out_latch = lf_out_latch;
        o.hf_out_latch = hf_out_latch; o.sequencing = sequencing;
        o.overrun = overrun;           o.lf_rd = lf_rd_addr;
        o.hf_rd = hf_rd_addr;          o.coef = coef_addr;
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected write for the next rise: HF every rise, LF on every other rise.
    task automatic push_rise();
        wr_t w;
        w.lf_en   = (n_rise % 2 == 0);
        w.lf_addr = w.lf_en ? 3'((n_rise / 2) % LFD) : 3'd0;
        w.hf_addr = 3'(n_rise % HFD);
        wr_q.push_back(w);
        n_rise++;
    endtask

    task automatic pop_wr(input string name);
        wr_t w;
        w = wr_q.pop_front();
        check(name, 32'({lf_wr_en, lf_wr_addr, hf_wr_en, hf_wr_addr}),
              32'({w.lf_en, w.lf_addr, 1'b1, w.hf_addr}));
    endtask

    task automatic rise();
        push_rise();
        valid_rise = 1'b1;
        tick();
        valid_rise = 1'b0;
        pop_wr($sformatf("write%0d", n_rise));
        if (sequencing) seq_seen = 1'b1;
    endtask

    task automatic idle(input int cyc);
        repeat (cyc) begin
            tick();
            if (sequencing) seq_seen = 1'b1;
        end
    endtask

    // Checks one pass from its CLR cycle through DONE; r1/r2 are cycle offsets
    // from the starting rise at which extra rises are driven (0 = none).
    task automatic run_pass(input int hb, input int lb, input logic lfp,
                            input int r1, input int r2, input string name);
        obs_t e;
        int   k;
        for (int j = 0; j < 9; j++) begin
            e = '0;
            e.sequencing = 1'b1;
            if (j == 0) begin
                e.acc_clr = 1'b1;
            end else if (j < 8) begin
                k = j - 1;
                e.hf_acc_en = 1'b1;
                e.coef      = 3'(k);
                e.hf_rd     = 3'((hb + k) % HFD);
                if (lfp && k < LFD) begin
                    e.lf_acc_en = 1'b1;
                    e.lf_rd     = 3'((lb + k) % LFD);
                end
            end else begin
                e.hf_out_latch = 1'b1;
                e.lf_out_latch = lfp;
            end
            e.overrun   = (r2 != 0) && (j == r2);
            rows[j].exp = e;
            rows[j].vr  = ((r1 != 0) && (j == r1 - 1)) || ((r2 != 0) && (j == r2 - 1));
        end
        for (int j = 0; j < 9; j++) begin
            check($sformatf("%s_row%0d", name, j), 32'(observe()), 32'(rows[j].exp));
            if (j < 8) begin
                if (rows[j].vr) begin
                    push_rise();
                    valid_rise = 1'b1;
                end
                tick();
                if (rows[j].vr) begin
                    valid_rise = 1'b0;
                    pop_wr($sformatf("%s_wr%0d", name, j));
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_rise = 1'b0;
        repeat (3) tick();
        check("reset_obs", 32'(observe()), 32'd0);
        check("reset_wr", 32'({lf_wr_en, lf_wr_addr, hf_wr_en, hf_wr_addr}), 32'd0);
        check("reset_state", 32'(dut.state_q), 32'd0);
        rst = 1'b0;
        idle(5);

        seq_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rise();
            idle(19);
        end
        check("fill_no_pass", 32'(seq_seen), 32'd0);

        // Rise 9: HF base 2, LF base 0, LF pass.
        rise();
        run_pass(2, 0, 1'b1, 0, 0, "pass9");
        tick();
        check("pass9_end", 32'(sequencing), 32'd0);
        idle(10);

        // Rise 10: HF-only pass.
        rise();
        run_pass(3, 0, 1'b0, 0, 0, "pass10");
        tick();
        check("pass10_end", 32'(sequencing), 32'd0);
        idle(10);

        // Rise 11 starts a pass; rises at +3 and +5 set pending then overrun.
        rise();
        run_pass(4, 1, 1'b1, 3, 5, "pend_a");
        tick();
        run_pass(6, 2, 1'b1, 0, 0, "pend_b");
        tick();
        check("pend_end", 32'(sequencing), 32'd0);
        idle(10);

        // Reset in the middle of a pass at k=3.
        rise();
        repeat (4) tick();
        check("mid_k3", 32'(coef_addr), 32'd3);
        rst = 1'b1;
        tick();
        check("rst_mid_obs", 32'(observe()), 32'd0);
        check("rst_mid_wr", 32'({lf_wr_en, lf_wr_addr, hf_wr_en, hf_wr_addr}), 32'd0);
        rst = 1'b0;
        wr_q.delete();
        n_rise = 0;
        seq_seen = 1'b0;
        idle(19);
        for (int i = 0; i < 8; i++) begin
            rise();
            idle(19);
        end
        check("refill_no_pass", 32'(seq_seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eq_seq_ctrl.md
EQ_SEQ_CTRL -- requirements
Module: eq_seq_ctrl

Interface
REQ-001 SHALL have parameter LF_DEPTH, default 1021, meaning low-frequency queue depth and LF filter tap count.
REQ-002 SHALL have parameter HF_DEPTH, default 1531, meaning high-frequency queue depth and HF filter tap count; HF_DEPTH >= LF_DEPTH.
REQ-003 SHALL have one clock and a synchronous, active-high reset (ports clk, rst).
REQ-004 SHALL have these ports:
 - clk  in  1  system clock
 - rst  in  1  synchronous active-high reset
 - valid_rise  in  1  one-cycle pulse, new left/right sample pair present
 - lf_wr_en  out  1  write strobe, LF queues
 - lf_wr_addr  out  LF_AW  LF write address
 - hf_wr_en  out  1  write strobe, HF queues
 - hf_wr_addr  out  HF_AW  HF write address
 - lf_rd_addr  out  LF_AW  LF read address
 - hf_rd_addr  out  HF_AW  HF read address
 - coef_addr  out  HF_AW  shared coefficient ROM address (tap index k)
 - acc_clr  out  1  clear all band accumulators
 - lf_acc_en  out  1  accumulate enable, LP/B1/B2
 - hf_acc_en  out  1  accumulate enable, B3/HP
 - lf_out_latch  out  1  latch LF band results
 - hf_out_latch  out  1  latch HF band results
 - sequencing  out  1  filter pass in progress
 - overrun  out  1  one-cycle pulse, sample request dropped

Function
REQ-005 SHALL write HF on every valid_rise and LF on alternate valid_rise (decimate by 2); the first rise after reset writes LF.
REQ-006 SHALL drive wr_en pulses and wr_addr in the cycle after valid_rise; write pointers then advance mod depth.
REQ-007 SHALL keep saturating fill counters per queue; a pass starts only when both counters reach their DEPTH after the current write.
REQ-008 SHALL implement FSM IDLE -> CLR -> RUN -> DONE -> IDLE.
REQ-009 The CLR state SHALL occur in the same cycle as the wr_en pulse, assert acc_clr for 1 cycle, and latch the read bases = post-increment write pointers (oldest sample).
REQ-010 RUN SHALL last HF_DEPTH cycles with k = 0..HF_DEPTH-1; coef_addr = k; hf_rd_addr = (hf_base+k) mod HF_DEPTH; hf_acc_en = 1 throughout.
REQ-011 In RUN, lf_rd_addr = (lf_base+k) mod LF_DEPTH and lf_acc_en = 1 only for k < LF_DEPTH, and only if this pass wrote LF; otherwise lf_acc_en = 0 and lf_rd_addr = 0.
REQ-012 DONE SHALL last 1 cycle: hf_out_latch = 1; lf_out_latch = 1 only if LF was written this pass.
REQ-013 sequencing SHALL be 1 in CLR, RUN and DONE (HF_DEPTH+2 cycles per pass).
REQ-014 valid_rise while not IDLE: write still occurs per REQ-005/006; a 1-deep pending flag is set; DONE then goes directly to CLR.
REQ-015 valid_rise while pending is already set: that write occurs; overrun pulses 1 cycle; pending stays single.
REQ-016 All outputs SHALL be registered; address and strobe outputs SHALL be 0 when inactive.

Reset
REQ-017 rst SHALL force state IDLE, all outputs 0, pointers, fill counters, pending and LF phase to 0; applies mid-pass, aborting it with no out_latch.
REQ-018 After reset, a full refill SHALL be required before the next pass.

Structure
REQ-019 The shared package SHALL hold LF_AW = clog2(LF_DEPTH), HF_AW = clog2(HF_DEPTH), and the FSM state enum.
REQ-020 One sub-module, mod_addr_ctr (wrapping pointer/counter with load and increment), SHALL be instantiated for the write pointers and read index.

Verification (LF_DEPTH=5, HF_DEPTH=7, rises spaced 20 cycles)
REQ-021 Reset: assert rst 3 cycles -> all outputs 0, state IDLE.
REQ-022 Fill: 8 rises -> hf_wr_addr 0..6,0; lf_wr_addr 0..3 on rises 1,3,5,7; sequencing never 1.
REQ-023 9th rise at cycle t -> at t+1: lf_wr_addr 4, hf_wr_addr 1, acc_clr = 1. Cycles t+2..t+8: hf_rd_addr 2,3,4,5,6,0,1. Cycles t+2..t+6: lf_rd_addr 0..4 with lf_acc_en = 1. At t+9: both out_latch = 1. sequencing = 1 for 9 cycles.
REQ-024 10th rise -> HF write only; lf_acc_en and lf_out_latch stay 0; hf_out_latch pulses.
REQ-025 Rises 3 and 5 cycles after pass start -> pending set; DONE goes straight to CLR; overrun pulses once on the second rise.
REQ-026 rst asserted at RUN k=3 -> next cycle all outputs 0; the next 8 rises produce no pass.
